// File: rtl/core_bus_ram_target.sv
// rtl/core_bus_ram_target.sv - single-beat bus target backed by a word-addressed RAM with wait states
module core_bus_ram_target #(
  parameter int          ADDR_BITS   = 12,
  parameter logic [29:0] BASE        = 30'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_start,
  input  logic        bus_write,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_data_be,
  output logic        bus_ready,
  output logic [31:0] bus_data_rd,
  output logic        bus_error,
  output logic        protocol_violation
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [31:0]           data_q;
  logic [3:0]            be_q;
  logic                  in_range_q;
  logic                  ready_q;
  logic                  error_q;
  logic [31:0]           rdata_q;
  logic                  viol_q;

  logic [31:0]           mem [DEPTH];

  logic                  hit_d;
  logic                  mem_edge_d;
  logic                  mem_we_d;

  // Window check compares only the bits above the RAM index, so the window never aliases.
  assign hit_d      = (bus_addr[29:ADDR_BITS] == BASE[29:ADDR_BITS]);
  // The memory operation happens on the edge that ends the last ACCESS cycle.
  assign mem_edge_d = (state_q == ACCESS) && (cnt_q == 4'd0);
  // A reset coinciding with the memory edge drops the write.
  assign mem_we_d   = mem_edge_d && write_q && in_range_q && !rst;

  // Byte-lane RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[addr_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

  // Request FSM: latch, count wait states, perform the access, pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'h0;
      be_q       <= 4'h0;
      in_range_q <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= 32'h0;
      viol_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (bus_start) begin
            write_q    <= bus_write;
            addr_q     <= bus_addr[ADDR_BITS-1:0];
            data_q     <= bus_data_wr;
            be_q       <= bus_data_be;
            in_range_q <= hit_d;
            cnt_q      <= 4'(WAIT_STATES);
            state_q    <= ACCESS;
          end else begin
            state_q    <= IDLE;
          end
        end
        ACCESS: begin
          if (bus_start) begin
            viol_q <= 1'b1;
          end
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!write_q) begin
              rdata_q <= in_range_q ? mem[addr_q] : 32'h0;
            end
            ready_q <= 1'b1;
            error_q <= !in_range_q;
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_ready          = ready_q;
  assign bus_error          = error_q;
  assign bus_data_rd        = rdata_q;
  assign protocol_violation = viol_q;

endmodule

// File: tb/tb_core_bus_ram_target.sv
// tb/tb_core_bus_ram_target.sv - directed bench for core_bus_ram_target at WAIT_STATES 1, 3 and 0
module tb_core_bus_ram_target;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start;
  logic        wr;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [2:0]  rdy;
  logic [2:0]  err;
  logic [2:0]  pv;
  logic [31:0] rd [3];

  int n_assert = 0;
  int n_fail   = 0;

  // index 0: WAIT_STATES=1, index 1: WAIT_STATES=3, index 2: WAIT_STATES=0
  core_bus_ram_target #(.ADDR_BITS(12), .BASE(30'h0), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .bus_start(start[0]), .bus_write(wr), .bus_addr(addr),
    .bus_data_wr(wdata), .bus_data_be(be), .bus_ready(rdy[0]), .bus_data_rd(rd[0]),
    .bus_error(err[0]), .protocol_violation(pv[0]));

  core_bus_ram_target #(.ADDR_BITS(12), .BASE(30'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .bus_start(start[1]), .bus_write(wr), .bus_addr(addr),
    .bus_data_wr(wdata), .bus_data_be(be), .bus_ready(rdy[1]), .bus_data_rd(rd[1]),
    .bus_error(err[1]), .protocol_violation(pv[1]));

  core_bus_ram_target #(.ADDR_BITS(12), .BASE(30'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus_start(start[2]), .bus_write(wr), .bus_addr(addr),
    .bus_data_wr(wdata), .bus_data_be(be), .bus_ready(rdy[2]), .bus_data_rd(rd[2]),
    .bus_error(err[2]), .protocol_violation(pv[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    start    = 3'b000;
    start[i] = 1'b1;
    wr       = w;
    addr     = a;
    wdata    = d;
    be       = b;
  endtask

  // Issue one request at the current negedge, check ready exactly lat cycles later and low after.
  task automatic xfer(input int i, input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int lat, input logic exp_err,
                      input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int early;
    early = 0;
    drive(i, w, a, d, b);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) start = 3'b000;
      if (k < lat && rdy[i]) early++;
    end
    chk({tag, " early_ready"}, early, 0);
    chk({tag, " ready"}, {31'b0, rdy[i]}, 1);
    chk({tag, " error"}, {31'b0, err[i]}, {31'b0, exp_err});
    if (chk_rd) chk({tag, " rdata"}, rd[i], exp_rd);
    @(negedge clk);
    chk({tag, " ready_drop"}, {31'b0, rdy[i]}, 0);
  endtask

  // Two reads, the second started in the ready cycle of the first.
  task automatic b2b(input int i, input int lat, input logic [29:0] a1, input logic [31:0] e1,
                     input logic [29:0] a2, input logic [31:0] e2, input string tag);
    int extra;
    extra = 0;
    drive(i, 1'b0, a1, 32'h0, 4'hF);
    for (int k = 1; k <= 2*lat + 1; k++) begin
      @(negedge clk);
      if (k == 1 || k == lat + 1) start = 3'b000;
      if (k == lat) begin
        chk({tag, " first_ready"}, {31'b0, rdy[i]}, 1);
        chk({tag, " first_rdata"}, rd[i], e1);
        drive(i, 1'b0, a2, 32'h0, 4'hF);
      end else if (k == 2*lat) begin
        chk({tag, " second_ready"}, {31'b0, rdy[i]}, 1);
        chk({tag, " second_rdata"}, rd[i], e2);
      end else if (rdy[i]) begin
        extra++;
      end
    end
    chk({tag, " stray_ready"}, extra, 0);
    chk({tag, " no_violation"}, {31'b0, pv[i]}, 0);
  endtask

  initial begin
    int extra;
    rst   = 1'b1;
    start = 3'b000;
    wr    = 1'b0;
    addr  = 30'h0;
    wdata = 32'h0;
    be    = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("reset ready", {31'b0, rdy[i]}, 0);
      chk("reset error", {31'b0, err[i]}, 0);
      chk("reset violation", {31'b0, pv[i]}, 0);
      chk("reset rdata", rd[i], 32'h0);
    end

    // 1: basic write/read, WAIT_STATES=1
    xfer(0, 1'b1, 30'h5, 32'hDEADBEEF, 4'hF, 3, 1'b0, 1'b0, 32'h0, "t1 write");
    xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'hDEADBEEF, "t1 read");

    // 2: byte enables
    xfer(0, 1'b1, 30'h5, 32'h11223344, 4'b0101, 3, 1'b0, 1'b0, 32'h0, "t2 write_be5");
    xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'hDE22BE44, "t2 read_be5");
    xfer(0, 1'b1, 30'h5, 32'hFFFFFFFF, 4'b0000, 3, 1'b0, 1'b0, 32'h0, "t2 write_be0");
    xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'hDE22BE44, "t2 read_be0");

    // 3: out of window
    xfer(0, 1'b1, 30'h1005, 32'hFFFFFFFF, 4'hF, 3, 1'b1, 1'b0, 32'h0, "t3 oor_write");
    xfer(0, 1'b0, 30'h1005, 32'h0, 4'hF, 3, 1'b1, 1'b1, 32'h0, "t3 oor_read");
    xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'hDE22BE44, "t3 alias_read");

    // 4: back-to-back
    xfer(0, 1'b1, 30'h6, 32'h66666666, 4'hF, 3, 1'b0, 1'b0, 32'h0, "t4 prep");
    b2b(0, 3, 30'h5, 32'hDE22BE44, 30'h6, 32'h66666666, "t4 b2b");

    // 5: start while busy
    drive(0, 1'b0, 30'h5, 32'h0, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 30'h5, 32'h0, 4'hF);
    @(negedge clk);
    start = 3'b000;
    chk("t5 violation_set", {31'b0, pv[0]}, 1);
    chk("t5 no_early_ready", {31'b0, rdy[0]}, 0);
    @(negedge clk);
    chk("t5 ready", {31'b0, rdy[0]}, 1);
    chk("t5 rdata", rd[0], 32'hDE22BE44);
    chk("t5 error", {31'b0, err[0]}, 0);
    @(negedge clk);
    chk("t5 single_ready", {31'b0, rdy[0]}, 0);
    xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'hDE22BE44, "t5 reread");
    chk("t5 violation_sticky", {31'b0, pv[0]}, 1);

    // 6: reset mid-access, WAIT_STATES=3
    xfer(1, 1'b1, 30'h7, 32'h0BADF00D, 4'hF, 5, 1'b0, 1'b0, 32'h0, "t6 prep7");
    xfer(1, 1'b1, 30'h5, 32'h12345678, 4'hF, 5, 1'b0, 1'b0, 32'h0, "t6 prep5");
    xfer(1, 1'b0, 30'h5, 32'h0, 4'hF, 5, 1'b0, 1'b1, 32'h12345678, "t6 preread");
    extra = 0;
    drive(1, 1'b1, 30'h7, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    start = 3'b000;
    if (rdy[1]) extra++;
    @(negedge clk);
    rst = 1'b1;
    if (rdy[1]) extra++;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 ready_after_rst", {31'b0, rdy[1]}, 0);
    chk("t6 violation_after_rst", {31'b0, pv[1]}, 0);
    chk("t6 rdata_after_rst", rd[1], 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdy[1]) extra++;
    end
    chk("t6 no_ready_pulse", extra, 0);
    xfer(1, 1'b0, 30'h7, 32'h0, 4'hF, 5, 1'b0, 1'b1, 32'h0BADF00D, "t6 read7");
    xfer(1, 1'b0, 30'h5, 32'h0, 4'hF, 5, 1'b0, 1'b1, 32'h12345678, "t6 read5");

    // 7: WAIT_STATES=0
    xfer(2, 1'b1, 30'h5, 32'hDEADBEEF, 4'hF, 2, 1'b0, 1'b0, 32'h0, "t7 write");
    xfer(2, 1'b0, 30'h5, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'hDEADBEEF, "t7 read");
    xfer(2, 1'b1, 30'h6, 32'h66666666, 4'hF, 2, 1'b0, 1'b0, 32'h0, "t7 prep");
    b2b(2, 2, 30'h5, 32'hDEADBEEF, 30'h6, 32'h66666666, "t7 b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_ram_target.md
Name: core_bus_ram_target

Overview:
- Bus responder (target end) of the core memory bus driven by the MMU arbiter.
- Accepts single-beat read and write requests: bus_start, bus_addr, bus_write, bus_data_wr, bus_data_be.
- Services requests from an on-chip word-addressed RAM with configurable wait states.
- Returns completion on bus_ready, with read data on bus_data_rd.
- Sits on the bus side of the arbiter; usable as boot/scratch RAM in simulation and FPGA builds.

Parameters:
ADDR_BITS, 12, log2 of RAM depth in 32-bit words (4096 words default).
BASE, 30'h0, word-address base of the window; must be aligned to 2**ADDR_BITS.
WAIT_STATES, 1, extra access cycles inserted before the memory operation (0..15).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
bus_start  input  1  one-cycle request strobe; request fields are valid only in this cycle
bus_write  input  1  1 = write, 0 = read
bus_addr  input  30  word address (ptr)
bus_data_wr  input  32  write data (word)
bus_data_be  input  4  byte enables for writes; bit i enables byte [8i+7:8i]
bus_ready  output  1  one-cycle completion strobe
bus_data_rd  output  32  read data; valid in the bus_ready cycle of a read
bus_error  output  1  asserted with bus_ready when the request missed the window
protocol_violation  output  1  sticky flag: bus_start seen while busy

Behaviour:
- Reset values (rst high at a rising edge): state IDLE; bus_ready=0; bus_error=0; bus_data_rd=0; protocol_violation=0; wait counter=0. RAM contents are not cleared.
- States: IDLE, ACCESS, RESP.
- IDLE or RESP with bus_start=1:
  - latch write, addr, data and be;
  - in_range = (bus_addr[29:ADDR_BITS] == BASE[29:ADDR_BITS]);
  - load wait counter with WAIT_STATES; go to ACCESS.
- RESP with bus_start=0: go to IDLE.
- ACCESS, counter != 0: decrement and stay in ACCESS.
- ACCESS, counter == 0, at that edge:
  - in-range write: for each set be bit, RAM[addr[ADDR_BITS-1:0]] byte is replaced by the latched data byte; clear bytes are unchanged.
  - in-range read: bus_data_rd is loaded with the full RAM word; be is ignored.
  - out-of-range read: bus_data_rd is loaded with 32'h0.
  - out-of-range write: no RAM change.
  - in all cases, go to RESP.
- RESP: bus_ready=1 for exactly one cycle; bus_error=!in_range. bus_ready and bus_error are 0 in all other states.
- bus_data_rd holds its last value until the next read completes; write responses do not change it.
- Latency: a start in cycle T gives bus_ready in cycle T+2+WAIT_STATES.
- Back-to-back: a start in the RESP cycle is accepted, with the same latency as from IDLE.
- bus_start during ACCESS:
  - the start is ignored (no latch);
  - protocol_violation is set and stays 1 until rst;
  - the in-flight request completes unaffected.
- Write with be=4'b0000 completes normally with no RAM change.
- Write followed by a read to the same address returns the new data; there is no forwarding hazard because accesses are serialized.
- Reset mid-operation: returns to IDLE with no bus_ready pulse for the aborted request.
  - A write whose memory edge has not occurred is dropped.
  - Writes that already completed are retained.
- bus_data_rd is 0 after reset until the first read completes.
- No combinational path from bus inputs to outputs; all outputs are registered.
- RAM is a single-port synchronous array, inferable as block RAM.

Test Plan:
1. WAIT_STATES=1, BASE=0:
   - write addr 30'h5, data 32'hDEADBEEF, be 4'hF at cycle T -> bus_ready=1 only in cycle T+3, bus_error=0;
   - read 30'h5 -> bus_data_rd=32'hDEADBEEF in its ready cycle.
2. Byte enables:
   - after test 1, write 30'h5, data 32'h11223344, be 4'b0101;
   - read 30'h5 -> 32'hDE22BE44;
   - write with be 4'b0000 then read -> still 32'hDE22BE44.
3. Out of range (ADDR_BITS=12, BASE=0):
   - write 30'h1005 with data 32'hFFFFFFFF -> ready with bus_error=1;
   - read 30'h1005 -> bus_error=1, bus_data_rd=0;
   - read 30'h5 -> 32'hDE22BE44, bus_error=0 (no aliasing).
4. Back-to-back:
   - read 30'h5 at T, second read 30'h6 asserted in cycle T+3 (the ready cycle);
   - second ready at T+6; protocol_violation stays 0.
5. Violation:
   - read at T, extra bus_start at T+1 (write 30'h5, data 0) -> protocol_violation=1 from T+2 onward;
   - single ready at T+3;
   - subsequent read of 30'h5 shows unchanged data.
6. Reset mid-access:
   - write 30'h7, data 32'hA5A5A5A5 at T with WAIT_STATES=3; rst high in cycle T+2;
   - no bus_ready pulse; protocol_violation=0; bus_data_rd=0;
   - read 30'h7 returns the prior contents, and 30'h5 is unchanged.
7. WAIT_STATES=0 build: start at T -> ready at T+2; repeat tests 1 and 4 with the adjusted cycle numbers.
